pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, 5, register-address width.
REQ-002 Parameter LOAD_USE_STALL, 1, cycles inserted for a load feeding a non-control ID instruction.
REQ-003 Parameter LOAD_CTRL_STALL, 2, cycles inserted for a load feeding a branch or JALR in ID.
REQ-004 Parameter ALU_CTRL_STALL, 1, cycles inserted for an ALU result feeding a branch or JALR in ID.
REQ-005 Parameter MAX_STALL, 4, counter ceiling; every *_STALL parameter SHALL be 0..MAX_STALL, checked at elaboration.
REQ-006 Ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-007 Ports: id_attempt_branch in 1; id_branch_taken in 1; id_predict_taken in 1; id_is_jalr in 1; id_rs1 in REG_AW; id_rs2 in REG_AW.
REQ-008 Ports: ex_reg_write in 1; ex_mem_read in 1; ex_rd in REG_AW; ex_busy in 1 (multi-cycle EX unit not done).
REQ-009 Ports: mem_req in 1; mem_ready in 1 (data-memory handshake); exc_valid in 1 (MEM-stage exception or interrupt taken).
REQ-010 Ports: stall_if out 1 (hold PC and IF/ID); bubble_ex out 1 (zero ID/EX control); stall_back out 1 (hold ID/EX and EX/MEM); flush_if out 1 (clear IF/ID); mispredict out 1; exc_flush out 1; stall_cnt out $clog2(MAX_STALL+1) (remaining cycles, debug).

Function
REQ-011 A dependency match SHALL require ex_rd != 0 and ex_rd equal to id_rs1, or to id_rs2; for JALR only id_rs1 SHALL count.
REQ-012 Hazard demand SHALL be, highest priority first: load+branch/JALR -> LOAD_CTRL_STALL; load+any use -> LOAD_USE_STALL; ex_reg_write+branch/JALR -> ALU_CTRL_STALL; else 0.
REQ-013 FSM states SHALL be IDLE and COUNT.
REQ-014 In IDLE with demand N>0: stall_if=1 and bubble_ex=1 that cycle; N=1 stays IDLE; N>1 goes to COUNT with counter=N-1.
REQ-015 In COUNT: stall_if=1 and bubble_ex=1; counter decrements each cycle; IDLE is entered on the cycle the counter reaches 1 (total stall = N cycles exactly).
REQ-016 In COUNT new demand SHALL be ignored (ID instruction frozen); in IDLE, demand is re-evaluated every non-frozen cycle.
REQ-017 Back-pressure freeze = ex_busy or (mem_req and not mem_ready): stall_back=1, stall_if=1, bubble_ex=0, and FSM state and counter SHALL hold unchanged.
REQ-018 mispredict=1 iff id_attempt_branch and id_branch_taken != id_predict_taken and no hazard stall, no freeze; flush_if SHALL equal mispredict or exc_flush.
REQ-019 exc_flush SHALL equal exc_valid combinationally and override everything: stall_if=0, stall_back=0, bubble_ex=1, mispredict=0; FSM forced to IDLE, counter to 0 next edge.
REQ-020 Simultaneous freeze and new demand in IDLE: freeze wins; demand is evaluated after the freeze clears.
REQ-021 All outputs except stall_cnt SHALL be combinational from inputs and state; stall_cnt SHALL be registered state (0 in IDLE).
REQ-022 Parameter value 0 for a hazard class SHALL disable that stall (no stall_if assertion).

Reset
REQ-023 rst SHALL force IDLE and counter=0 asynchronously; during rst all outputs SHALL be 0 except combinational exc_flush/flush_if/bubble_ex driven by exc_valid.
REQ-024 rst asserted mid-COUNT SHALL abandon the stall; the first post-reset cycle with no demand SHALL show stall_if=0.

Verification
REQ-025 ex_mem_read=1, ex_rd=5, id_attempt_branch=1, id_rs2=5, defaults -> stall_if=bubble_ex=1 for exactly 2 cycles, stall_cnt 1 then 0.
REQ-026 ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall; ex_reg_write=1, ex_rd=3, id_is_jalr=1, id_rs2=3 only -> no stall.
REQ-027 In COUNT with stall_cnt=1, mem_req=1, mem_ready=0 for 3 cycles -> stall_back=1, stall_cnt stays 1 for 3 cycles, then one more stall cycle.
REQ-028 Branch with id_predict_taken=0, id_branch_taken=1 during a load-branch stall -> mispredict=0 until stall ends, then mispredict=flush_if=1 for 1 cycle.
REQ-029 exc_valid=1 on cycle 1 of a 2-cycle stall -> exc_flush=flush_if=1, stall_if=0 that cycle, stall_cnt=0 next cycle.
REQ-030 LOAD_CTRL_STALL=4 build, load-branch hazard -> exactly 4 stall cycles, stall_cnt 3,2,1,0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use and control-dependency stall counting,
// back-pressure freeze, branch-mispredict and exception flush generation.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW          = 5,
  parameter int unsigned LOAD_USE_STALL  = 1,
  parameter int unsigned LOAD_CTRL_STALL = 2,
  parameter int unsigned ALU_CTRL_STALL  = 1,
  parameter int unsigned MAX_STALL       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_attempt_branch,
  input  logic                             id_branch_taken,
  input  logic                             id_predict_taken,
  input  logic                             id_is_jalr,
  input  logic [REG_AW-1:0]                id_rs1,
  input  logic [REG_AW-1:0]                id_rs2,
  input  logic                             ex_reg_write,
  input  logic                             ex_mem_read,
  input  logic [REG_AW-1:0]                ex_rd,
  input  logic                             ex_busy,
  input  logic                             mem_req,
  input  logic                             mem_ready,
  input  logic                             exc_valid,
  output logic                             stall_if,
  output logic                             bubble_ex,
  output logic                             stall_back,
  output logic                             flush_if,
  output logic                             mispredict,
  output logic                             exc_flush,
  output logic [$clog2(MAX_STALL+1)-1:0]   stall_cnt
);

  localparam int unsigned CW = $clog2(MAX_STALL + 1);

  if (MAX_STALL < 1) begin : g_bad_max
    $error("MAX_STALL must be at least 1");
  end
  if (LOAD_USE_STALL > MAX_STALL) begin : g_bad_lu
    $error("LOAD_USE_STALL exceeds MAX_STALL");
  end
  if (LOAD_CTRL_STALL > MAX_STALL) begin : g_bad_lc
    $error("LOAD_CTRL_STALL exceeds MAX_STALL");
  end
  if (ALU_CTRL_STALL > MAX_STALL) begin : g_bad_ac
    $error("ALU_CTRL_STALL exceeds MAX_STALL");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   demand;
  logic            dep_hit;
  logic            is_ctrl;
  logic            freeze;
  logic            mp_cond;

  // Hazard demand: JALR only reads rs1, so rs2 matches are ignored for it.
  always_comb begin
    dep_hit = (ex_rd != '0) &&
              ((ex_rd == id_rs1) || (!id_is_jalr && (ex_rd == id_rs2)));
    is_ctrl = id_attempt_branch | id_is_jalr;
    demand  = '0;
    if (ex_mem_read && dep_hit && is_ctrl) begin
      demand = CW'(LOAD_CTRL_STALL);
    end else if (ex_mem_read && dep_hit) begin
      demand = CW'(LOAD_USE_STALL);
    end else if (ex_reg_write && dep_hit && is_ctrl) begin
      demand = CW'(ALU_CTRL_STALL);
    end
    freeze  = ex_busy | (mem_req & ~mem_ready);
    mp_cond = id_attempt_branch & (id_branch_taken ^ id_predict_taken);
  end

  // Next-state and outputs; exception beats reset-idle beats freeze beats stall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_if   = 1'b0;
    bubble_ex  = 1'b0;
    stall_back = 1'b0;
    mispredict = 1'b0;
    if (exc_valid) begin
      bubble_ex = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (freeze) begin
      stall_back = 1'b1;
      stall_if   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (demand != '0) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
            if (demand > CW'(1)) begin
              state_d = COUNT;
              cnt_d   = demand - CW'(1);
            end
          end else begin
            mispredict = mp_cond;
          end
        end
        COUNT: begin
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    exc_flush = exc_valid;
    flush_if  = mispredict | exc_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed corner sequences plus random traffic,
// checked against a remaining-stall-cycles reference model for two builds.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_attempt_branch, id_branch_taken, id_predict_taken, id_is_jalr;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_busy, mem_req, mem_ready, exc_valid;

  logic          a_stall_if, a_bubble_ex, a_stall_back, a_flush_if, a_mispredict, a_exc_flush;
  logic [2:0]    a_stall_cnt;
  logic          b_stall_if, b_bubble_ex, b_stall_back, b_flush_if, b_mispredict, b_exc_flush;
  logic [2:0]    b_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int rem_a    = 0;
  int rem_b    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst(rst),
    .id_attempt_branch(id_attempt_branch), .id_branch_taken(id_branch_taken),
    .id_predict_taken(id_predict_taken), .id_is_jalr(id_is_jalr),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_busy(ex_busy), .mem_req(mem_req), .mem_ready(mem_ready), .exc_valid(exc_valid),
    .stall_if(a_stall_if), .bubble_ex(a_bubble_ex), .stall_back(a_stall_back),
    .flush_if(a_flush_if), .mispredict(a_mispredict), .exc_flush(a_exc_flush),
    .stall_cnt(a_stall_cnt)
  );

  pipeline_hazard_ctrl #(.LOAD_CTRL_STALL(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .id_attempt_branch(id_attempt_branch), .id_branch_taken(id_branch_taken),
    .id_predict_taken(id_predict_taken), .id_is_jalr(id_is_jalr),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_busy(ex_busy), .mem_req(mem_req), .mem_ready(mem_ready), .exc_valid(exc_valid),
    .stall_if(b_stall_if), .bubble_ex(b_bubble_ex), .stall_back(b_stall_back),
    .flush_if(b_flush_if), .mispredict(b_mispredict), .exc_flush(b_exc_flush),
    .stall_cnt(b_stall_cnt)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
  endtask

  // Stall cycles the ID instruction needs against what sits in EX.
  function automatic int demand(input int load_ctrl);
    bit hit, ctrl;
    hit  = (ex_rd != 0) && ((ex_rd == id_rs1) || (!id_is_jalr && ex_rd == id_rs2));
    ctrl = id_attempt_branch || id_is_jalr;
    if (ex_mem_read && hit) return ctrl ? load_ctrl : 1;
    if (ex_reg_write && hit && ctrl) return 1;
    return 0;
  endfunction

  // Expected {stall_if,bubble_ex,stall_back,flush_if,mispredict,exc_flush}.
  // rem = stall cycles still owed by the frozen ID instruction.
  function automatic logic [5:0] model(input int rem, input int dmd, output int rem_nxt);
    int live;
    rem_nxt = rem;
    if (exc_valid) begin
      rem_nxt = 0;
      return 6'b010101;
    end
    if (rst) begin
      rem_nxt = 0;
      return 6'b000000;
    end
    if (ex_busy || (mem_req && !mem_ready)) return 6'b101000;
    live = (rem > 0) ? rem : dmd;
    if (live > 0) begin
      rem_nxt = live - 1;
      return 6'b110000;
    end
    rem_nxt = 0;
    if (id_attempt_branch && (id_branch_taken != id_predict_taken)) return 6'b000110;
    return 6'b000000;
  endfunction

  // Inputs are set just after a rising edge; check, then advance to the next one.
  task automatic cycle();
    logic [5:0] exp_a, exp_b;
    int nxt_a, nxt_b;
    #1;
    exp_a = model(rem_a, demand(2), nxt_a);
    exp_b = model(rem_b, demand(4), nxt_b);
    check_eq("a_outs", int'({a_stall_if, a_bubble_ex, a_stall_back, a_flush_if,
                             a_mispredict, a_exc_flush}), int'(exp_a));
    check_eq("a_stall_cnt", int'(a_stall_cnt), rst ? 0 : rem_a);
    check_eq("b_outs", int'({b_stall_if, b_bubble_ex, b_stall_back, b_flush_if,
                             b_mispredict, b_exc_flush}), int'(exp_b));
    check_eq("b_stall_cnt", int'(b_stall_cnt), rst ? 0 : rem_b);
    @(posedge clk);
    rem_a = nxt_a;
    rem_b = nxt_b;
    #1;
  endtask

  task automatic clear_inputs();
    id_attempt_branch = 1'b0; id_branch_taken = 1'b0; id_predict_taken = 1'b0;
    id_is_jalr = 1'b0; id_rs1 = '0; id_rs2 = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    ex_busy = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; exc_valid = 1'b0;
  endtask

  task automatic load_branch_rs2_5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_attempt_branch = 1'b1; id_rs2 = 5'd5;
  endtask

  task automatic idle_cycles(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    cycle();
    exc_valid = 1'b1;
    cycle();
    exc_valid = 1'b0;
    rst = 1'b0;
    idle_cycles(2);

    // Load feeding a branch via rs2: 2 cycles on the default build, 4 on the other.
    load_branch_rs2_5();
    for (int i = 0; i < 4; i++) cycle();
    idle_cycles(2);

    // No stall from x0, nor from rs2 on a JALR.
    ex_mem_read = 1'b1; ex_rd = '0; id_rs1 = '0;
    cycle();
    clear_inputs();
    ex_reg_write = 1'b1; ex_rd = 5'd3; id_is_jalr = 1'b1; id_rs2 = 5'd3; id_rs1 = 5'd1;
    cycle();
    idle_cycles(1);

    // Memory back-pressure while the counter sits at 1.
    load_branch_rs2_5();
    cycle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1'b1;
    cycle();
    clear_inputs();
    load_branch_rs2_5();
    ex_mem_read = 1'b0; ex_rd = '0;
    idle_cycles(3);

    // Mispredict is held off by the load-branch stall, then flushes once.
    load_branch_rs2_5();
    id_branch_taken = 1'b1; id_predict_taken = 1'b0;
    cycle();
    cycle();
    ex_mem_read = 1'b0; ex_rd = '0;
    cycle();
    id_attempt_branch = 1'b0;
    idle_cycles(3);

    // Exception on the first cycle of a 2-cycle stall.
    load_branch_rs2_5();
    exc_valid = 1'b1;
    cycle();
    exc_valid = 1'b0; ex_mem_read = 1'b0;
    cycle();
    idle_cycles(1);

    // Reset in the middle of a counted stall.
    load_branch_rs2_5();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle_cycles(2);

    // Random traffic over a narrow register range so dependencies are frequent.
    for (int i = 0; i < 4000; i++) begin
      rst               = ($urandom_range(0, 149) == 0);
      exc_valid         = ($urandom_range(0, 29) == 0);
      ex_busy           = ($urandom_range(0, 9) == 0);
      mem_req           = 1'($urandom_range(0, 1));
      mem_ready         = ($urandom_range(0, 3) != 0);
      ex_mem_read       = 1'($urandom_range(0, 1));
      ex_reg_write      = 1'($urandom_range(0, 1));
      ex_rd             = AW'($urandom_range(0, 3));
      id_rs1            = AW'($urandom_range(0, 3));
      id_rs2            = AW'($urandom_range(0, 3));
      id_attempt_branch = ($urandom_range(0, 2) == 0);
      id_is_jalr        = ($urandom_range(0, 3) == 0);
      id_branch_taken   = 1'($urandom_range(0, 1));
      id_predict_taken  = 1'($urandom_range(0, 1));
      cycle();
    end
    rst = 1'b0;
    idle_cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
